// File: rtl/cpc_fifo_pkg.sv
// Shared types and constants for the CPC<->Pi FIFO host controller.
`timescale 1ns/1ps
package cpc_fifo_pkg;

   // Sequencer states
   typedef enum logic [2:0] {
      S_IDLE,
      S_WR_SI,
      S_RD_OE,
      S_RD_SOB,
      S_ST_RD,
      S_RST,
      S_HOLD
   } state_t;

   // Status byte bit positions
   localparam int ST_DOR = 0;
   localparam int ST_DIR = 1;
   localparam int ST_OVF = 2;
   localparam int ST_UNF = 3;

   // Value of A0 selecting each port of the window
   localparam logic PORT_DATA = 1'b0;
   localparam logic PORT_CTRL = 1'b1;

   // Control register bits
   localparam int CTL_MR  = 0;
   localparam int CTL_CLR = 1;

   // Largest of three counts, used to size the shared down-counter
   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return m;
   endfunction

   // Assemble the status byte from the flags
   function automatic logic [7:0] status_byte(input logic unf, input logic ovf,
                                              input logic dir, input logic dor);
      logic [7:0] s;
      s         = 8'h00;
      s[ST_UNF] = unf;
      s[ST_OVF] = ovf;
      s[ST_DIR] = dir;
      s[ST_DOR] = dor;
      return s;
   endfunction

endpackage

// File: rtl/cpc_sync2.sv
// Two-flop synchroniser for the asynchronous FIFO ready flags.
`timescale 1ns/1ps
module cpc_sync2 (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta;

   // Two back-to-back flops, both cleared by reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/cpc_fifo_host_ctrl.sv
// Host-side sequencer for the CPC<->Pi FIFO link: decodes Z80 I/O cycles
// to a two-port window and generates the 40105 shift/control strobes.
//
// Strobe timing: every strobe is registered and appears one CLK after the
// access is sampled in IDLE. Timed strobes load the shared counter with
// N-1 on entry (the entry cycle is the first of N) and drop when it is 0.
// After a reset the counter starts at MR_CYCLES, so fifo_mr stays high for
// MR_CYCLES clocks after release on top of the reset time itself.
`timescale 1ns/1ps
module cpc_fifo_host_ctrl
   import cpc_fifo_pkg::*;
#(
   parameter logic [15:0] PORT_BASE  = 16'hFD80,
   parameter int          SI_CYCLES  = 2,
   parameter int          SOB_CYCLES = 2,
   parameter int          MR_CYCLES  = 4
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic [15:0] addr,
   input  logic [7:0]  din,
   input  logic        iorq_b,
   input  logic        rd_b,
   input  logic        wr_b,
   input  logic        m1_b,
   input  logic        fifo_dir,
   input  logic        fifo_dor,
   output logic        fifo_si,
   output logic        fifo_sob,
   output logic        fifo_oeb,
   output logic        fifo_mr,
   output logic [7:0]  dout,
   output logic        dout_en
);

   localparam int CNT_MAX = max3(SI_CYCLES, SOB_CYCLES, MR_CYCLES);
   localparam int CW      = $clog2(CNT_MAX + 1);

   state_t          state;
   logic [CW-1:0]   cnt;
   logic            ovf;
   logic            unf;
   logic            dir_s;
   logic            dor_s;

   logic            hit;
   logic            access;
   logic            is_read;
   logic            sel_ctrl;
   logic            rd_active;
   logic            unused_din;

   cpc_sync2 u_sync_dir (.clk(CLK), .rst(RESET), .d(fifo_dir), .q(dir_s));
   cpc_sync2 u_sync_dor (.clk(CLK), .rst(RESET), .d(fifo_dor), .q(dor_s));

   // Bus decode; INTACK (iorq_b and m1_b both low) is never an access
   assign hit        = (addr[15:1] == PORT_BASE[15:1]);
   assign access     = !iorq_b && m1_b && hit && (!rd_b || !wr_b);
   assign is_read    = !rd_b;              // rd_b and wr_b both low reads
   assign sel_ctrl   = (addr[0] == PORT_CTRL);
   assign rd_active  = !iorq_b && !rd_b;
   assign unused_din = ^din[7:2];

   // Sequencer FSM with registered strobes, sticky flags and shared counter
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state    <= S_RST;
         cnt      <= CW'(MR_CYCLES);
         fifo_si  <= 1'b0;
         fifo_sob <= 1'b1;
         fifo_oeb <= 1'b1;
         fifo_mr  <= 1'b1;
         dout_en  <= 1'b0;
         dout     <= 8'h00;
         ovf      <= 1'b0;
         unf      <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (access) begin
                  if (is_read) begin
                     if (sel_ctrl == PORT_DATA) begin
                        if (dor_s) begin
                           fifo_oeb <= 1'b0;
                           state    <= S_RD_OE;
                        end else begin
                           unf   <= 1'b1;
                           state <= S_HOLD;
                        end
                     end else begin
                        dout    <= status_byte(unf, ovf, dir_s, dor_s);
                        dout_en <= 1'b1;
                        state   <= S_ST_RD;
                     end
                  end else begin
                     if (sel_ctrl == PORT_DATA) begin
                        if (dir_s) begin
                           fifo_si <= 1'b1;
                           cnt     <= CW'(SI_CYCLES - 1);
                           state   <= S_WR_SI;
                        end else begin
                           ovf   <= 1'b1;
                           state <= S_HOLD;
                        end
                     end else if (din[CTL_MR]) begin
                        fifo_mr <= 1'b1;
                        cnt     <= CW'(MR_CYCLES - 1);
                        state   <= S_RST;
                     end else begin
                        if (din[CTL_CLR]) begin
                           ovf <= 1'b0;
                           unf <= 1'b0;
                        end
                        state <= S_HOLD;
                     end
                  end
               end
            end

            S_WR_SI: begin
               if (cnt != '0) begin
                  cnt <= cnt - CW'(1);
               end else begin
                  fifo_si <= 1'b0;
                  state   <= S_HOLD;
               end
            end

            S_RD_OE: begin
               if (!rd_active) begin
                  fifo_oeb <= 1'b1;
                  fifo_sob <= 1'b0;
                  cnt      <= CW'(SOB_CYCLES - 1);
                  state    <= S_RD_SOB;
               end
            end

            S_RD_SOB: begin
               if (cnt != '0) begin
                  cnt <= cnt - CW'(1);
               end else begin
                  fifo_sob <= 1'b1;
                  state    <= S_IDLE;
               end
            end

            S_ST_RD: begin
               if (!rd_active) begin
                  dout_en <= 1'b0;
                  ovf     <= 1'b0;
                  unf     <= 1'b0;
                  state   <= S_IDLE;
               end
            end

            S_RST: begin
               if (cnt != '0) begin
                  cnt <= cnt - CW'(1);
               end else begin
                  fifo_mr <= 1'b0;
                  state   <= S_HOLD;
               end
            end

            S_HOLD: begin
               if (iorq_b) state <= S_IDLE;
            end

            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cpc_fifo_host_ctrl.sv
// Directed bench for cpc_fifo_host_ctrl: Z80 I/O cycles against the FIFO window.
`timescale 1ns/1ps
module tb_cpc_fifo_host_ctrl;

   logic        CLK;
   logic        RESET;
   logic [15:0] addr;
   logic [7:0]  din;
   logic        iorq_b, rd_b, wr_b, m1_b;
   logic        fifo_dir, fifo_dor;
   logic        fifo_si, fifo_sob, fifo_oeb, fifo_mr;
   logic [7:0]  dout;
   logic        dout_en;

   int checks = 0;
   int errors = 0;

   cpc_fifo_host_ctrl dut (
      .CLK(CLK), .RESET(RESET), .addr(addr), .din(din),
      .iorq_b(iorq_b), .rd_b(rd_b), .wr_b(wr_b), .m1_b(m1_b),
      .fifo_dir(fifo_dir), .fifo_dor(fifo_dor),
      .fifo_si(fifo_si), .fifo_sob(fifo_sob), .fifo_oeb(fifo_oeb), .fifo_mr(fifo_mr),
      .dout(dout), .dout_en(dout_en)
   );

   // clock and watchdog
   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   // strobe monitor, sampled on the falling edge
   int   cyc = 0, si_cnt = 0, si_rise = 0, si_first = 0, si_bad = 0;
   int   oeb_cnt = 0, oeb_bad = 0, sob_cnt = 0, sob_bad = 0, mr_cnt = 0;
   logic si_prev = 1'b0;

   always @(negedge CLK) begin
      cyc     <= cyc + 1;
      si_prev <= fifo_si;
      if (fifo_si) begin
         si_cnt <= si_cnt + 1;
         if (wr_b) si_bad <= si_bad + 1;
         if (!si_prev) begin
            si_rise  <= si_rise + 1;
            si_first <= cyc + 1;
         end
      end
      if (!fifo_oeb) begin
         oeb_cnt <= oeb_cnt + 1;
         if (iorq_b || rd_b) oeb_bad <= oeb_bad + 1;
      end
      if (!fifo_sob) begin
         sob_cnt <= sob_cnt + 1;
         if (!fifo_oeb || (!iorq_b && !rd_b)) sob_bad <= sob_bad + 1;
      end
      if (fifo_mr) mr_cnt <= mr_cnt + 1;
   end

   // snapshots for per-test deltas
   int s_si_cnt, s_si_rise, s_si_bad, s_oeb_cnt, s_oeb_bad, s_sob_cnt, s_sob_bad, s_mr_cnt;
   int start_cyc;
   logic       rd_seen;
   logic [7:0] rd_val;

   task automatic snap();
      s_si_cnt  = si_cnt;  s_si_rise = si_rise; s_si_bad  = si_bad;
      s_oeb_cnt = oeb_cnt; s_oeb_bad = oeb_bad;
      s_sob_cnt = sob_cnt; s_sob_bad = sob_bad; s_mr_cnt  = mr_cnt;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // driver tasks
   task automatic io_cycle(input logic [15:0] a, input logic rd, input logic wr,
                           input logic [7:0] d, input int hold, input logic m1);
      @(negedge CLK); #1;
      start_cyc = cyc;
      addr = a; din = d; m1_b = m1;
      iorq_b = 1'b0; rd_b = !rd; wr_b = !wr;
      rd_seen = 1'b0; rd_val = 8'h00;
      repeat (hold) begin
         @(negedge CLK);
         if (dout_en) begin
            rd_seen = 1'b1;
            rd_val  = dout;
         end
      end
      #1;
      iorq_b = 1'b1; rd_b = 1'b1; wr_b = 1'b1; m1_b = 1'b1;
      repeat (6) @(negedge CLK);
   endtask

   task automatic io_wr(input logic [15:0] a, input logic [7:0] d, input int hold);
      io_cycle(a, 1'b0, 1'b1, d, hold, 1'b1);
   endtask

   task automatic io_rd(input logic [15:0] a, input int hold);
      io_cycle(a, 1'b1, 1'b0, 8'h00, hold, 1'b1);
   endtask

   task automatic status_chk(input string tag, input logic [7:0] exp);
      io_rd(16'hFD81, 3);
      chk({tag, "_en"}, rd_seen, 1'b1);
      chk(tag, rd_val, exp);
   endtask

   task automatic set_flags(input logic dir, input logic dor);
      @(negedge CLK); #1;
      fifo_dir = dir; fifo_dor = dor;
      repeat (4) @(negedge CLK);
   endtask

   // release RESET and measure the fifo_mr pulse that follows
   task automatic release_reset(input string tag);
      int n;
      @(negedge CLK); #1;
      RESET = 1'b0;
      n = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge CLK);
         if (fifo_mr) n++;
         else break;
      end
      chk(tag, n, 4);
      repeat (2) @(negedge CLK);
   endtask

   initial begin
      RESET = 1'b1; addr = 16'h0000; din = 8'h00;
      iorq_b = 1'b1; rd_b = 1'b1; wr_b = 1'b1; m1_b = 1'b1;
      fifo_dir = 1'b0; fifo_dor = 1'b0;

      // 1: reset values and the power-on MR pulse
      repeat (3) @(negedge CLK);
      chk("rst_si", fifo_si, 1'b0);
      chk("rst_sob", fifo_sob, 1'b1);
      chk("rst_oeb", fifo_oeb, 1'b1);
      chk("rst_mr", fifo_mr, 1'b1);
      chk("rst_dout_en", dout_en, 1'b0);
      chk("rst_dout", dout, 8'h00);
      release_reset("rst_mr_len");
      status_chk("rst_status", 8'h00);

      // 2: accepted writes, normal and with wait states
      set_flags(1'b1, 1'b0);
      snap();
      io_wr(16'hFD80, 8'h5A, 3);
      chk("wr_si_len", si_cnt - s_si_cnt, 2);
      chk("wr_si_pulses", si_rise - s_si_rise, 1);
      chk("wr_si_latency", si_first - start_cyc, 1);
      chk("wr_si_in_wr", si_bad - s_si_bad, 0);
      status_chk("wr_status", 8'h02);
      snap();
      io_wr(16'hFD80, 8'hC3, 6);
      chk("wr_wait_si_len", si_cnt - s_si_cnt, 2);
      chk("wr_wait_pulses", si_rise - s_si_rise, 1);
      chk("wr_wait_in_wr", si_bad - s_si_bad, 0);

      // 3: write into a full FIFO sets ovf, status read clears it
      set_flags(1'b0, 1'b0);
      snap();
      io_wr(16'hFD80, 8'hA5, 3);
      chk("ovf_no_si", si_rise - s_si_rise, 0);
      status_chk("ovf_status", 8'h04);
      status_chk("ovf_cleared", 8'h00);

      // 4: data reads with and without data available
      set_flags(1'b0, 1'b1);
      snap();
      io_rd(16'hFD80, 3);
      chk("rd_oe_len", oeb_cnt - s_oeb_cnt, 3);
      chk("rd_oe_window", oeb_bad - s_oeb_bad, 0);
      chk("rd_sob_len", sob_cnt - s_sob_cnt, 2);
      chk("rd_sob_after", sob_bad - s_sob_bad, 0);
      chk("rd_no_drive", rd_seen, 1'b0);
      snap();
      io_rd(16'hFD80, 5);
      chk("rd_long_oe_len", oeb_cnt - s_oeb_cnt, 5);
      chk("rd_long_sob_len", sob_cnt - s_sob_cnt, 2);
      status_chk("rd_status", 8'h01);
      set_flags(1'b0, 1'b0);
      snap();
      io_rd(16'hFD80, 3);
      chk("unf_no_oe", oeb_cnt - s_oeb_cnt, 0);
      chk("unf_no_sob", sob_cnt - s_sob_cnt, 0);
      chk("unf_no_drive", rd_seen, 1'b0);
      status_chk("unf_status", 8'h08);

      // 5: control writes, INTACK and foreign addresses
      set_flags(1'b1, 1'b0);
      snap();
      io_wr(16'hFD80, 8'h11, 3);
      io_wr(16'hFD81, 8'h01, 3);
      chk("ctl_mr_si", si_rise - s_si_rise, 1);
      chk("ctl_mr_len", mr_cnt - s_mr_cnt, 4);
      snap();
      io_wr(16'hFD80, 8'h22, 3);
      chk("ctl_after_si", si_rise - s_si_rise, 1);
      chk("ctl_after_mr", mr_cnt - s_mr_cnt, 0);
      set_flags(1'b0, 1'b0);
      io_wr(16'hFD80, 8'h33, 3);
      io_wr(16'hFD81, 8'h00, 3);
      status_chk("ctl_noclr_status", 8'h04);
      snap();
      io_wr(16'hFD80, 8'h44, 3);
      io_rd(16'hFD80, 3);
      io_wr(16'hFD81, 8'h02, 3);
      chk("ctl_clr_mr", mr_cnt - s_mr_cnt, 0);
      status_chk("ctl_clr_status", 8'h00);
      set_flags(1'b1, 1'b1);
      snap();
      io_cycle(16'hFD80, 1'b0, 1'b1, 8'h55, 3, 1'b0);
      io_cycle(16'hFD80, 1'b1, 1'b0, 8'h00, 3, 1'b0);
      io_wr(16'hFD82, 8'h66, 3);
      io_rd(16'hFD82, 3);
      chk("foreign_no_drive", rd_seen, 1'b0);
      io_wr(16'hFC81, 8'h01, 3);
      chk("foreign_si", si_rise - s_si_rise, 0);
      chk("foreign_oe", oeb_cnt - s_oeb_cnt, 0);
      chk("foreign_sob", sob_cnt - s_sob_cnt, 0);
      chk("foreign_mr", mr_cnt - s_mr_cnt, 0);
      snap();
      io_cycle(16'hFD81, 1'b1, 1'b1, 8'h01, 3, 1'b1);
      chk("rdwr_is_read", rd_seen, 1'b1);
      chk("rdwr_status", rd_val, 8'h03);
      chk("rdwr_no_mr", mr_cnt - s_mr_cnt, 0);

      // 6: RESET during WR_SI and during RD_SOB
      @(negedge CLK); #1;
      addr = 16'hFD80; din = 8'h77; iorq_b = 1'b0; wr_b = 1'b0;
      @(negedge CLK);
      chk("abort_wr_si_on", fifo_si, 1'b1);
      #1 RESET = 1'b1;
      #1;
      chk("abort_wr_si", fifo_si, 1'b0);
      chk("abort_wr_mr", fifo_mr, 1'b1);
      chk("abort_wr_sob", fifo_sob, 1'b1);
      iorq_b = 1'b1; wr_b = 1'b1;
      release_reset("abort_wr_mr_len");
      @(negedge CLK); #1;
      addr = 16'hFD80; iorq_b = 1'b0; rd_b = 1'b0;
      repeat (2) @(negedge CLK);
      #1;
      iorq_b = 1'b1; rd_b = 1'b1;
      @(negedge CLK);
      chk("abort_rd_sob_on", fifo_sob, 1'b0);
      #1 RESET = 1'b1;
      #1;
      chk("abort_rd_sob", fifo_sob, 1'b1);
      chk("abort_rd_mr", fifo_mr, 1'b1);
      chk("abort_rd_oeb", fifo_oeb, 1'b1);
      release_reset("abort_rd_mr_len");
      status_chk("final_status", 8'h03);
      snap();
      io_wr(16'hFD80, 8'h88, 3);
      chk("final_si_pulses", si_rise - s_si_rise, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
